// File: rtl/iiitb_usr_rx.sv
// iiitb_usr_rx: serial-to-parallel receiver for the iiitb_usr serializer link.
// Rebuilds MSB-bit words from a strobed bit stream in either shift direction.
// Each finished word goes into a registered holding register with a valid/ready
// handshake. The receiver also reports frame resynchronisation and overruns.
// Optional feature: define IIITB_USR_RX_PARITY_EN to expect one even-parity bit
// after each word. parity_err then reports the parity status of the held word.
//
// Handshake: a word held in data_out is consumed on any rising edge where
// data_valid and data_ready are both high. A new word may load on that same edge.
// If a new word finishes while the old word is still unconsumed, the new word is
// dropped and overrun pulses.
module iiitb_usr_rx #(
    parameter int MSB = 8
) (
    input  logic           clock,
    input  logic           clear,
    input  logic           serial_in,
    input  logic           serial_valid,
    input  logic           frame,
    input  logic           dir,
    input  logic           data_ready,
    output logic [MSB-1:0] data_out,
    output logic           data_valid,
    output logic           overrun,
    output logic           sync_err,
    output logic           parity_err
);

    localparam int CW = $clog2(MSB + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT
`ifdef IIITB_USR_RX_PARITY_EN
        , S_PAR
`endif
    } state_t;

    // FSM state is kept in state_q so it can be probed by name.
    state_t         state_q;
    logic [MSB-1:0] sr_q;
    logic [CW-1:0]  cnt_q;
    logic           dir_q;
    logic [MSB-1:0] data_out_q;
    logic           data_valid_q;
    logic           overrun_q;
    logic           sync_err_q;
    logic           parity_err_q;

    logic           shift_dir_d;
    logic [MSB-1:0] sr_shift_d;
    logic           word_done_d;
    logic [MSB-1:0] word_d;
    logic           perr_d;
    logic           can_load_d;

    // Shift path: a frame bit uses the live dir input; other bits use the latched direction.
    always_comb begin
        shift_dir_d = frame ? dir : dir_q;
        if (shift_dir_d) begin
            sr_shift_d = {serial_in, sr_q[MSB-1:1]};
        end else begin
            sr_shift_d = {sr_q[MSB-2:0], serial_in};
        end
    end

    // Word-completion detect and the word/parity that would be delivered this edge.
    always_comb begin
        word_done_d = 1'b0;
        word_d      = sr_shift_d;
        perr_d      = 1'b0;
        if (serial_valid && !frame) begin
`ifdef IIITB_USR_RX_PARITY_EN
            if (state_q == S_PAR) begin
                word_done_d = 1'b1;
                word_d      = sr_q;
                perr_d      = ^{sr_q, serial_in};
            end
`else
            if (state_q == S_SHIFT && cnt_q == CW'(MSB - 1)) begin
                word_done_d = 1'b1;
            end
`endif
        end
        can_load_d = !data_valid_q || data_ready;
    end

    // Receiver FSM, output holding register and status pulses.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q      <= S_IDLE;
            sr_q         <= '0;
            cnt_q        <= '0;
            dir_q        <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            sync_err_q   <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            overrun_q  <= 1'b0;
            sync_err_q <= 1'b0;

            if (word_done_d) begin
                if (can_load_d) begin
                    data_out_q   <= word_d;
                    data_valid_q <= 1'b1;
                    parity_err_q <= perr_d;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (data_valid_q && data_ready) begin
                data_valid_q <= 1'b0;
            end

            if (serial_valid) begin
                if (frame) begin
                    // A frame bit always restarts the word; mid-word it discards the partial word.
                    if (state_q != S_IDLE) begin
                        sync_err_q <= 1'b1;
                    end
                    dir_q   <= dir;
                    sr_q    <= sr_shift_d;
                    cnt_q   <= CW'(1);
                    state_q <= S_SHIFT;
                end else begin
                    case (state_q)
                        S_SHIFT: begin
                            sr_q  <= sr_shift_d;
                            cnt_q <= cnt_q + CW'(1);
                            if (cnt_q == CW'(MSB - 1)) begin
`ifdef IIITB_USR_RX_PARITY_EN
                                state_q <= S_PAR;
`else
                                state_q <= S_IDLE;
`endif
                            end
                        end
`ifdef IIITB_USR_RX_PARITY_EN
                        S_PAR: begin
                            state_q <= S_IDLE;
                        end
`endif
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign overrun    = overrun_q;
    assign sync_err   = sync_err_q;
    assign parity_err = parity_err_q;

endmodule

// File: doc/iiitb_usr_rx.md
# iiitb_usr_rx

Serial-to-parallel receiver that sits at the far end of the link driven by the universal shift register (`iiitb_usr`) when that register is used as a serializer. It reassembles MSB-bit words from a strobed serial bit stream, in either shift direction, and presents each word on a registered parallel output with a valid/ready handshake. It also handles frame resynchronisation and overrun reporting.

## Interface
- `MSB`, default 8: word width in bits; legal range 2..32.
- `clock`  in  1  rising-edge clock; the only clock.
- `clear`  in  1  synchronous, active-high reset; takes priority over every other input.
- `serial_in`  in  1  serial data bit; sampled only when `serial_valid`=1.
- `serial_valid`  in  1  bit strobe; one bit is accepted per cycle it is high.
- `frame`  in  1  word-start marker; qualified by `serial_valid`; marks the current bit as bit 0 of a new word.
- `dir`  in  1  0 = left-shift / MSB-first; 1 = right-shift / LSB-first; sampled on the frame bit only.
- `data_ready`  in  1  downstream accepts `data_out` when high together with `data_valid`.
- `data_out`  out  MSB  received word (output holding register).
- `data_valid`  out  1  `data_out` holds an unconsumed word.
- `overrun`  out  1  one-cycle pulse: a completed word was dropped.
- `sync_err`  out  1  one-cycle pulse: `frame` arrived mid-word and the partial word was discarded.
- `parity_err`  out  1  parity status of the word in `data_out`; constant 0 when parity is compiled out.

## Operation
- The shift register `sr[MSB-1:0]`, bit counter `cnt` (0..MSB), latched direction `dir_q`, and states IDLE, SHIFT, PAR (PAR exists only with parity enabled).
- **IDLE**
  - Bits with `serial_valid`=1 and `frame`=0 are ignored.
  - On `serial_valid`&`frame`: latch `dir_q`=`dir`, shift in the bit, set `cnt`=1, go to SHIFT.
- **Shift rule**
  - `dir_q`=0: `sr <= {sr[MSB-2:0], serial_in}`. The first bit lands in `data_out[MSB-1]`.
  - `dir_q`=1: `sr <= {serial_in, sr[MSB-1:1]}`. The first bit lands in `data_out[0]`.
- **SHIFT**
  - Each `serial_valid`&!`frame` shifts one bit and increments `cnt`.
  - `serial_valid`&`frame` pulses `sync_err`, discards the partial word, and restarts exactly as from IDLE with this bit.
- **Word complete** (the shift that makes `cnt`=MSB)
  - Without parity: the completed word is delivered and the state returns to IDLE.
  - With parity: the state goes to PAR.
- **PAR**
  - The next `serial_valid` bit is the even-parity bit.
  - `parity_err` is the XOR of the 8 data bits and the parity bit, loaded alongside the word.
  - The word is then delivered and the state returns to IDLE.
  - `frame` on this bit behaves as in SHIFT: `sync_err` pulses, the word is dropped, and a new word starts.
- **Delivery**
  - If `data_valid`=0, or `data_valid`&`data_ready` in the same cycle: `data_out` <= word and `data_valid` <= 1.
  - Otherwise the word is dropped, `overrun` pulses, and `data_out`/`data_valid`/`parity_err` are unchanged.
- **Consumption**: `data_valid`&`data_ready` with no simultaneous delivery clears `data_valid`. `data_out` keeps its last value.
- **Reset**: `clear` sets `data_out`=0, `data_valid`=0, `overrun`=0, `sync_err`=0, `parity_err`=0, `sr`=0, `cnt`=0, state IDLE. A word in progress is abandoned and no pulse is raised.
- `dir` changes mid-word have no effect until the next frame bit.

## Timing
- All outputs are registered and update only on the rising `clock` edge.
- Latency: `data_valid` rises on the same edge that samples the last data bit (or the parity bit with parity enabled). Minimum word time is MSB cycles (MSB+1 with parity).
- `overrun` and `sync_err` are high for exactly one cycle, in the cycle following the causing edge.
- Back-to-back words are supported: a frame bit may immediately follow the last bit of the previous word, with no idle cycle.
- Gaps (`serial_valid`=0) of any length inside a word are legal and do not alter state.
- A `data_ready` with `data_valid`=0 has no effect.

## Configuration
- `IIITB_USR_RX_PARITY_EN` defined:
  - The PAR state is present.
  - Each word is followed by one even-parity bit.
  - `parity_err` reports a mismatch for the currently held word.
- Not defined:
  - There is no PAR state; the word is delivered on its last data bit.
  - `parity_err` is tied to 0.
  - The port list is identical in both builds.

## Test plan
- **MSB-first word**: clear for 1 cycle; `dir`=0, send 1,0,1,0,1,0,1,1 with `frame` on the first bit and `data_ready`=1 -> `data_out`=8'b10101011, `data_valid` high 1 cycle, no pulses.
- **LSB-first word**: `dir`=1, send 1,1,0,1,0,1,0,1 -> `data_out`=8'b10101011.
- **Overrun**: `data_ready`=0; send 8'hF0 then 8'h0F back-to-back -> `data_out`=8'hF0 held, `overrun` pulses once at the end of the second word; then raise `data_ready` -> `data_valid` falls.
- **Resync**: assert `frame` on bit 4, then send a full word 8'h3C -> `sync_err` pulses once, `data_out`=8'h3C.
- **Clear mid-word**: send 3 bits, assert `clear` for 1 cycle, then send 8'h55 -> all outputs 0 after clear, final `data_out`=8'h55.
- **Parity** (`IIITB_USR_RX_PARITY_EN` defined): send 8'hAB with parity 1 -> `parity_err`=0; send 8'hAB with parity 0 -> `parity_err`=1.
